delay_meter: RTL and testbench
==============================

DELAY_METER -- requirements
Module: delay_meter

Interface
REQ-001 Parameter MAX_COUNT, default 24'd10_000_000: timeout in clk cycles per trial phase (WAIT or SETTLE).
REQ-002 Parameter NUM_TRIALS, default 4: trials averaged per measurement; power of two, 1..16.
REQ-003 Parameter CNT_W, default 24: width of the cycle counter and the result.
REQ-004 clk  input  1  single clock; all state on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle request to begin a measurement; honoured only in IDLE.
REQ-007 probe_out  output  1  registered launch edge driven into the delay path under test.
REQ-008 probe_in  input  1  returning edge from the delay path; asynchronous to clk.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a measurement completes, with or without timeout.
REQ-011 timeout  output  1  sticky flag, set on any trial timeout, cleared on the next accepted start.
REQ-012 result  output  CNT_W  averaged delay in clk cycles, held until the next done.

Function
REQ-013 probe_in SHALL pass through a 2-flop synchronizer; rise = sync2 & ~sync2_q, fall = ~sync2 & sync2_q.
REQ-014 FSM states SHALL be IDLE, LAUNCH, WAIT, SETTLE, FINISH.
REQ-015 IDLE + start -> LAUNCH; clear accumulator, trial index and timeout.
REQ-016 LAUNCH (1 cycle) -> WAIT; probe_out goes high and the counter is set to 0 on the same edge.
REQ-017 In WAIT the counter SHALL increment each cycle; on rise, add (count - 2) to the accumulator and go to SETTLE, with probe_out going low on that edge.
REQ-018 With a zero-delay loopback (probe_in = probe_out), the trial value SHALL be 0; a path delaying by D whole cycles SHALL yield D.
REQ-019 In SETTLE the counter SHALL restart at 0; once sync2 is low, go to LAUNCH if trials remain, otherwise go to FINISH.
REQ-020 If the counter reaches MAX_COUNT-1 in WAIT or SETTLE, set timeout, force probe_out low, and go to FINISH.
REQ-021 FINISH (1 cycle) SHALL pulse done and go to IDLE.
REQ-022 On FINISH, result = accumulator >> log2(NUM_TRIALS) (truncating) if no timeout occurred, otherwise all ones.
REQ-023 The accumulator SHALL be CNT_W+log2(NUM_TRIALS) bits wide; no overflow is possible.
REQ-024 start SHALL be ignored while busy, and ignored in the same cycle as FINISH.
REQ-025 A rise seen in SETTLE (glitching path) SHALL be ignored; only sync2 low ends SETTLE.

Reset
REQ-026 rst SHALL force IDLE immediately, from any state including mid-WAIT.
REQ-027 rst SHALL clear to 0: probe_out, busy, done, timeout, result, counter, accumulator, trial index, and the synchronizer flops.
REQ-028 After rst deasserts, the first start SHALL launch a fresh measurement.

Structure
REQ-029 Package delay_meter_pkg SHALL hold the state enum and the constant SYNC_STAGES = 2 (the value subtracted in REQ-017).
REQ-030 One sub-module, sync_edge_det, SHALL implement the 2-flop synchronizer with rise/fall outputs.
REQ-031 No other hierarchy; expected size is 150-250 lines of RTL.

Verification
REQ-032 Loopback, NUM_TRIALS=4, start pulse -> done pulse; result=0; timeout=0.
REQ-033 probe_in = probe_out delayed by 5 registered cycles -> result=5.
REQ-034 Per-trial delays 3,4,3,4 with NUM_TRIALS=4 -> result=3 (14>>2).
REQ-035 MAX_COUNT=100, probe_in tied low -> done exactly 100 cycles after entering WAIT; timeout=1; result=all ones; next start clears timeout.
REQ-036 start pulsed during WAIT -> ignored (trial count and result unchanged).
REQ-037 rst asserted mid-WAIT -> busy and probe_out low immediately; no done; the next start gives a correct result.

Source files
------------

// File: rtl/delay_meter_pkg.sv
// delay_meter_pkg: shared FSM state type and synchronizer depth for delay_meter.
package delay_meter_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SETTLE, FINISH} state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer with a delayed copy for rise/fall detection.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic meta, prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) {meta, level, prev} <= '0;
    else {meta, level, prev} <= {d, meta, level};
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/delay_meter.sv
// delay_meter: launches probe edges, times their return and averages NUM_TRIALS trials.
module delay_meter
  import delay_meter_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 24'd10_000_000,
  parameter int NUM_TRIALS = 4,
  parameter int CNT_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic probe_out,
  input  logic probe_in,
  output logic busy,
  output logic done,
  output logic timeout,
  output logic [CNT_W-1:0] result
);
  localparam int LW = $clog2(NUM_TRIALS);
  localparam int TW = LW > 0 ? LW : 1;
  localparam int AW = CNT_W + LW;
  state_t state;
  logic [CNT_W-1:0] count;
  logic [AW-1:0] acc;
  logic [TW-1:0] trial;
  logic level, rise, fall_unused, expired, last;
  sync_edge_det u_sync (
    .clk(clk),
    .rst(rst),
    .d(probe_in),
    .level(level),
    .rise(rise),
    .fall(fall_unused)
  );
  assign expired = count == CNT_W'(MAX_COUNT - 1);
  assign last = trial == TW'(NUM_TRIALS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      probe_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
      result <= '0;
      count <= '0;
      acc <= '0;
      trial <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LAUNCH;
          busy <= 1'b1;
          acc <= '0;
          trial <= '0;
          timeout <= 1'b0;
        end
        LAUNCH: begin
          probe_out <= 1'b1;
          count <= '0;
          state <= WAIT;
        end
        WAIT, SETTLE: begin
          count <= count + CNT_W'(1);
          if (expired) begin
            probe_out <= 1'b0;
            timeout <= 1'b1;
            result <= '1;
            done <= 1'b1;
            state <= FINISH;
          end else if (state == WAIT && rise) begin
            // the synchronizer adds SYNC_STAGES cycles that are not part of the path
            acc <= acc + AW'(count - CNT_W'(SYNC_STAGES));
            probe_out <= 1'b0;
            count <= '0;
            state <= SETTLE;
          end else if (state == SETTLE && !level) begin
            if (last) begin
              result <= CNT_W'(acc >> LW);
              done <= 1'b1;
              state <= FINISH;
            end else begin
              trial <= trial + TW'(1);
              state <= LAUNCH;
            end
          end
        end
        FINISH: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_delay_meter.sv
// tb_delay_meter: randomized scoreboard bench; the delay path is modelled as a per-trial rise delay.
`timescale 1ns/1ps
module tb_delay_meter;
  localparam int NT = 4, MC = 100, CW = 24;
  logic clk = 0, rst = 1, start = 0, probe_in, probe_out, busy, done, timeout;
  logic [CW-1:0] result;
  int n_tests = 0, n_fail = 0, cyc = 0, since = 0, cur_d = 0;
  bit tie_low = 0;
  int dly_q[$];
  logic [CW:0] exp_q[$];

  delay_meter #(.MAX_COUNT(MC), .NUM_TRIALS(NT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .probe_out(probe_out), .probe_in(probe_in),
    .busy(busy), .done(done), .timeout(timeout), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    since <= probe_out ? since + 1 : 0;
  end
  // path under test: returns high cur_d cycles after launch, low as soon as probe drops
  assign probe_in = ~tie_low & probe_out & (since >= cur_d);
  always @(posedge probe_out) cur_d = dly_q.size() != 0 ? dly_q.pop_front() : 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst && done) begin
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL extra_done: done=1 got with no measurement pending, expected none");
    end else begin
      logic [CW:0] e;
      e = exp_q.pop_front();
      check("result", 32'(result), 32'(e[CW-1:0]));
      check("timeout", 32'(timeout), 32'(e[CW]));
    end
  end

  task automatic wait_idle();
    int i = 0;
    while ((busy || exp_q.size() != 0) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check("idle_busy", 32'(busy), 0);
    check("idle_pending", exp_q.size(), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_probe();
    int i = 0;
    while (!probe_out && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("probe_launch", 32'(probe_out), 1);
  endtask

  task automatic measure(int a, int b, int c, int d);
    int sum;
    wait_idle();
    dly_q = '{a, b, c, d};
    sum = a + b + c + d;
    exp_q.push_back({1'b0, CW'(sum / NT)});
    pulse_start();
  endtask

  initial begin
    int t0, i;
    repeat (2) @(negedge clk);
    check("rst_probe_out", 32'(probe_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_result", 32'(result), 0);
    rst = 0;
    measure(0, 0, 0, 0);
    measure(5, 5, 5, 5);
    measure(3, 4, 3, 4);
    for (int k = 0; k < 8; k++)
      measure($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12));
    // start during WAIT must not disturb the measurement
    measure(6, 3, 8, 5);
    wait_probe();
    repeat (2) @(negedge clk);
    pulse_start();
    // timeout with a dead path
    wait_idle();
    tie_low = 1;
    exp_q.push_back({1'b1, {CW{1'b1}}});
    pulse_start();
    wait_probe();
    t0 = cyc;
    i = 0;
    while (!done && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("timeout_latency", cyc - t0, MC);
    check("timeout_probe_low", 32'(probe_out), 0);
    tie_low = 0;
    wait_idle();
    check("timeout_sticky", 32'(timeout), 1);
    measure(2, 2, 2, 2);
    check("timeout_cleared", 32'(timeout), 0);
    // start coinciding with FINISH is ignored
    measure(1, 1, 1, 1);
    i = 0;
    while (!done && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("finish_done", 32'(done), 1);
    start = 1;
    @(negedge clk);
    start = 0;
    check("finish_start_ignored", 32'(busy), 0);
    @(negedge clk);
    check("finish_start_ignored2", 32'(busy), 0);
    // reset in the middle of WAIT
    wait_idle();
    dly_q = '{15, 15, 15, 15};
    pulse_start();
    wait_probe();
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_probe", 32'(probe_out), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_result", 32'(result), 0);
    @(negedge clk);
    rst = 0;
    dly_q.delete();
    measure(4, 5, 6, 7);
    wait_idle();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
